// File: rtl/ctrl_mc_pkg.sv
// Shared definitions for the ctrl_mc multicycle control unit: RV32I opcodes,
// controller states, ALUOp / PC-mode / writeback codes, byte-enable masks and
// the decoded control bundle passed from ctrl_mc_decode to ctrl_mc.
package ctrl_mc_pkg;

    // RV32I major opcodes handled by the controller
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FETCH,
        FETCH_WAIT,
        EXEC,
        MEM,
        MEM_WAIT,
        TRAP
    } state_t;

    // ALUOp codes
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_FUNCT  = 2'b01;
    localparam logic [1:0] ALU_PASS_B = 2'b10;
    localparam logic [1:0] ALU_IDLE   = 2'b11;

    // PC source (MODE) codes
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    // Writeback select codes
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Unshifted byte-enable masks, sized for the widest (64-bit) bus
    localparam logic [7:0] BE_BYTE  = 8'h01;
    localparam logic [7:0] BE_HALF  = 8'h03;
    localparam logic [7:0] BE_WORD  = 8'h0F;
    localparam logic [7:0] BE_DWORD = 8'hFF;

    typedef struct packed {
        logic       alu_src1;
        logic       alu_src2;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic [1:0] mode;
        logic       reg_we;
        logic       is_mem;
        logic       is_store;
        logic       is_branch;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        alu_src1:  1'b0,
        alu_src2:  1'b0,
        alu_op:    ALU_IDLE,
        wb_sel:    WB_ALU,
        mode:      PC_PLUS4,
        reg_we:    1'b0,
        is_mem:    1'b0,
        is_store:  1'b0,
        is_branch: 1'b0,
        illegal:   1'b0
    };

    // Access size (funct3[1:0]) to byte-enable mask
    function automatic logic [7:0] be_for_size(input logic [1:0] size);
        logic [7:0] be;
        case (size)
            2'b00:   be = BE_BYTE;
            2'b01:   be = BE_HALF;
            2'b10:   be = BE_WORD;
            default: be = BE_DWORD;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ctrl_mc_if.sv
// Instruction and data memory handshake bundle (req/gnt/r_valid) for ctrl_mc.
// master = controller side, slave = memory side.
interface ctrl_mc_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic            instr_req;
    logic            instr_gnt;
    logic            instr_r_valid;
    logic            data_req;
    logic            data_gnt;
    logic            data_r_valid;
    logic            data_we;
    logic [BE_W-1:0] data_be;

    modport master (
        output instr_req,
        input  instr_gnt,
        input  instr_r_valid,
        output data_req,
        input  data_gnt,
        input  data_r_valid,
        output data_we,
        output data_be
    );

    modport slave (
        input  instr_req,
        output instr_gnt,
        output instr_r_valid,
        input  data_req,
        output data_gnt,
        output data_r_valid,
        input  data_we,
        input  data_be
    );

endinterface

// File: rtl/ctrl_mc_decode.sv
// Purely combinational opcode decoder: produces ALU source selects, ALUOp,
// writeback select, jump PC mode and instruction-class flags. State gating is
// left to ctrl_mc.
module ctrl_mc_decode
    import ctrl_mc_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
);

    // Opcode to control bundle; unknown opcodes flag illegal
    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (opcode)
            OPC_LUI: begin
                ctrl.alu_src2 = 1'b1;
                ctrl.alu_op   = ALU_PASS_B;
                ctrl.reg_we   = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.alu_src1 = 1'b1;
                ctrl.alu_src2 = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                ctrl.reg_we   = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.alu_src2 = 1'b1;
                ctrl.alu_op   = ALU_FUNCT;
                ctrl.reg_we   = 1'b1;
            end
            OPC_OP: begin
                ctrl.alu_op = ALU_FUNCT;
                ctrl.reg_we = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.is_branch = 1'b1;
            end
            OPC_JAL: begin
                ctrl.mode   = PC_TARGET;
                ctrl.wb_sel = WB_PC4;
                ctrl.reg_we = 1'b1;
            end
            OPC_JALR: begin
                ctrl.mode   = PC_JALR;
                ctrl.wb_sel = WB_PC4;
                ctrl.reg_we = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.alu_src2 = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                ctrl.is_mem   = 1'b1;
            end
            OPC_STORE: begin
                ctrl.alu_src2 = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                ctrl.is_mem   = 1'b1;
                ctrl.is_store = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_mc.sv
// Multicycle RV32I control unit: FETCH -> FETCH_WAIT -> EXEC [-> MEM ->
// MEM_WAIT] -> FETCH, with TRAP on illegal opcodes or access sizes.
// Optional wait-state timeout enabled by defining CTRL_TIMEOUT_EN; without it
// waits are unbounded and bus_error is tied low.
module ctrl_mc
    import ctrl_mc_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       RES_N,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    ctrl_mc_if.master  bus,
    output logic       ir_we,
    output logic [1:0] MODE,
    output logic       pc_we,
    output logic       write_enable,
    output logic       ALUSrcMux1,
    output logic       ALUSrcMux2,
    output logic [1:0] ALUOp,
    output logic [1:0] wb_sel,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic       busy
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t state;
    state_t state_n;
    ctrl_t  dec;
    logic   size_bad;

    ctrl_mc_decode u_decode (
        .opcode (opcode),
        .ctrl   (dec)
    );

    // 64-bit accesses need a 64-bit bus; stores have no unsigned variants
    assign size_bad = ((funct3[1:0] == 2'b11) && (DATA_W == 32)) ||
                      (dec.is_store && funct3[2]);

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             tmo_trip;
    logic             bus_err_q;

    assign waiting = (state == FETCH_WAIT) || (state == MEM) || (state == MEM_WAIT);
`else
    // Timeout limit has no effect when the timeout logic is not built
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    // State register
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and output decode; reset forces all outputs to defaults
    always_comb begin
        state_n       = state;
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        bus.data_we   = 1'b0;
        bus.data_be   = '0;
        ir_we         = 1'b0;
        MODE          = PC_PLUS4;
        pc_we         = 1'b0;
        write_enable  = 1'b0;
        ALUSrcMux1    = 1'b0;
        ALUSrcMux2    = 1'b0;
        ALUOp         = ALU_IDLE;
        wb_sel        = WB_ALU;
        illegal_instr = 1'b0;
        busy          = 1'b0;
`ifdef CTRL_TIMEOUT_EN
        tmo_trip      = 1'b0;
`endif
        if (RES_N) begin
            busy = (state != FETCH);
            case (state)
                FETCH: begin
                    bus.instr_req = 1'b1;
                    if (bus.instr_gnt) begin
                        state_n = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.instr_r_valid) begin
                        ir_we   = 1'b1;
                        state_n = EXEC;
                    end
                end
                EXEC: begin
                    if (dec.illegal) begin
                        illegal_instr = 1'b1;
                        state_n       = TRAP;
                    end else begin
                        ALUSrcMux1 = dec.alu_src1;
                        ALUSrcMux2 = dec.alu_src2;
                        ALUOp      = dec.alu_op;
                        if (dec.is_mem) begin
                            state_n = MEM;
                        end else begin
                            wb_sel       = dec.wb_sel;
                            write_enable = dec.reg_we;
                            pc_we        = 1'b1;
                            MODE         = dec.is_branch ?
                                           (branch_taken ? PC_TARGET : PC_PLUS4) :
                                           dec.mode;
                            state_n      = FETCH;
                        end
                    end
                end
                MEM: begin
                    ALUSrcMux2 = 1'b1;
                    ALUOp      = ALU_ADD;
                    if (size_bad) begin
                        illegal_instr = 1'b1;
                        state_n       = TRAP;
                    end else begin
                        bus.data_req = 1'b1;
                        bus.data_we  = dec.is_store;
                        bus.data_be  = BE_W'(be_for_size(funct3[1:0]));
                        if (bus.data_gnt) begin
                            state_n = MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    ALUSrcMux2 = 1'b1;
                    ALUOp      = ALU_ADD;
                    if (bus.data_r_valid) begin
                        if (!dec.is_store) begin
                            wb_sel       = WB_MEM;
                            write_enable = 1'b1;
                        end
                        pc_we   = 1'b1;
                        MODE    = PC_PLUS4;
                        state_n = FETCH;
                    end
                end
                TRAP: begin
                    illegal_instr = 1'b1;
                end
                default: begin
                    state_n = TRAP;
                end
            endcase
`ifdef CTRL_TIMEOUT_EN
            // Trip when the counter is about to reach the limit without progress
            if (waiting && (state_n == state) &&
                (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                tmo_trip = 1'b1;
                state_n  = TRAP;
            end
`endif
        end
    end

`ifdef CTRL_TIMEOUT_EN
    // Wait-state counter (cleared on every state change) and sticky bus error
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_n != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (tmo_trip) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus_error = bus_err_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed self-checking bench for ctrl_mc: fetch handshake, ALU/branch/jump
// decode, load/store sequencing, illegal traps, reset recovery and the
// wait-state behaviour with and without CTRL_TIMEOUT_EN.
module tb_ctrl_mc;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic       CLK = 1'b0;
    logic       RES_N;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       ir_we;
    logic [1:0] MODE;
    logic       pc_we;
    logic       write_enable;
    logic       ALUSrcMux1;
    logic       ALUSrcMux2;
    logic [1:0] ALUOp;
    logic [1:0] wb_sel;
    logic       illegal_instr;
    logic       bus_error;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    ctrl_mc_if #(.DATA_W(32)) bus ();

    ctrl_mc #(
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK           (CLK),
        .RES_N         (RES_N),
        .opcode        (opcode),
        .funct3        (funct3),
        .branch_taken  (branch_taken),
        .bus           (bus.master),
        .ir_we         (ir_we),
        .MODE          (MODE),
        .pc_we         (pc_we),
        .write_enable  (write_enable),
        .ALUSrcMux1    (ALUSrcMux1),
        .ALUSrcMux2    (ALUSrcMux2),
        .ALUOp         (ALUOp),
        .wb_sel        (wb_sel),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From FETCH: zero-wait grant, then r_valid with the new instruction.
    // Returns 1 time unit into the EXEC cycle.
    task automatic fetch(input logic [6:0] opc, input logic [2:0] f3);
        @(negedge CLK);
        bus.instr_gnt = 1'b1;
        #1 chk("fetch_req", 8'(bus.instr_req), 8'd1);
        @(negedge CLK);
        bus.instr_gnt     = 1'b0;
        bus.instr_r_valid = 1'b1;
        opcode            = opc;
        funct3            = f3;
        #1 chk("fetch_ir_we", 8'(ir_we), 8'd1);
        @(negedge CLK);
        bus.instr_r_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RES_N = 1'b0;
        #1 chk("rst_req_drop", 8'(bus.instr_req), 8'd0);
        chk("rst_illegal_clr", 8'(illegal_instr), 8'd0);
        @(negedge CLK);
        RES_N = 1'b1;
        #1 chk("rst_release_req", 8'(bus.instr_req), 8'd1);
        chk("rst_release_busy", 8'(busy), 8'd0);
    endtask

    initial begin
        RES_N             = 1'b0;
        opcode            = 7'd0;
        funct3            = 3'd0;
        branch_taken      = 1'b0;
        bus.instr_gnt     = 1'b0;
        bus.instr_r_valid = 1'b0;
        bus.data_gnt      = 1'b0;
        bus.data_r_valid  = 1'b0;

        // Reset state, with a stray grant present
        @(negedge CLK);
        bus.instr_gnt = 1'b1;
        #1 chk("reset_instr_req", 8'(bus.instr_req), 8'd0);
        chk("reset_aluop", 8'(ALUOp), 8'd3);
        chk("reset_busy", 8'(busy), 8'd0);
        chk("reset_pc_we", 8'(pc_we), 8'd0);
        chk("reset_bus_error", 8'(bus_error), 8'd0);

        // OP with instr_gnt delayed 3 cycles; r_valid in the gnt cycle ignored
        @(negedge CLK);
        RES_N         = 1'b1;
        bus.instr_gnt = 1'b0;
        #1 chk("op_req_c1", 8'(bus.instr_req), 8'd1);
        for (int i = 2; i <= 3; i++) begin
            @(negedge CLK);
            #1 chk("op_req_wait", 8'(bus.instr_req), 8'd1);
        end
        @(negedge CLK);
        bus.instr_gnt     = 1'b1;
        bus.instr_r_valid = 1'b1;
        #1 chk("op_req_c4", 8'(bus.instr_req), 8'd1);
        chk("op_rvalid_in_gnt", 8'(ir_we), 8'd0);
        @(negedge CLK);
        bus.instr_gnt = 1'b0;
        opcode        = OP_OP;
        funct3        = 3'b000;
        #1 chk("op_req_c5", 8'(bus.instr_req), 8'd0);
        chk("op_ir_we", 8'(ir_we), 8'd1);
        chk("op_busy", 8'(busy), 8'd1);
        @(negedge CLK);
        bus.instr_r_valid = 1'b0;
        #1 chk("op_we", 8'(write_enable), 8'd1);
        chk("op_aluop", 8'(ALUOp), 8'd1);
        chk("op_pc_we", 8'(pc_we), 8'd1);
        chk("op_mux2", 8'(ALUSrcMux2), 8'd0);
        @(negedge CLK);
        #1 chk("op_c7_fetch", 8'(busy), 8'd0);
        chk("op_c7_req", 8'(bus.instr_req), 8'd1);

        // LOAD word, data_gnt delayed 2 cycles
        fetch(OP_LOAD, 3'b010);
        chk("ld_exec_mux2", 8'(ALUSrcMux2), 8'd1);
        chk("ld_exec_aluop", 8'(ALUOp), 8'd0);
        chk("ld_exec_pc_we", 8'(pc_we), 8'd0);
        @(negedge CLK);
        #1 chk("ld_req", 8'(bus.data_req), 8'd1);
        chk("ld_be", 8'(bus.data_be), 8'h0F);
        chk("ld_data_we", 8'(bus.data_we), 8'd0);
        @(negedge CLK);
        #1 chk("ld_req_hold", 8'(bus.data_req), 8'd1);
        @(negedge CLK);
        bus.data_gnt = 1'b1;
        #1 chk("ld_req_gnt", 8'(bus.data_req), 8'd1);
        @(negedge CLK);
        bus.data_gnt = 1'b0;
        #1 chk("ld_wait_req", 8'(bus.data_req), 8'd0);
        chk("ld_wait_mux2", 8'(ALUSrcMux2), 8'd1);
        chk("ld_wait_we", 8'(write_enable), 8'd0);
        @(negedge CLK);
        bus.data_r_valid = 1'b1;
        #1 chk("ld_wb_sel", 8'(wb_sel), 8'd1);
        chk("ld_we", 8'(write_enable), 8'd1);
        chk("ld_pc_we", 8'(pc_we), 8'd1);
        chk("ld_mode", 8'(MODE), 8'd0);
        @(negedge CLK);
        bus.data_r_valid = 1'b0;
        #1 chk("ld_done", 8'(busy), 8'd0);

        // STORE byte, zero-wait memory
        fetch(OP_STORE, 3'b000);
        chk("st_exec_we", 8'(write_enable), 8'd0);
        @(negedge CLK);
        bus.data_gnt = 1'b1;
        #1 chk("st_req", 8'(bus.data_req), 8'd1);
        chk("st_data_we", 8'(bus.data_we), 8'd1);
        chk("st_be", 8'(bus.data_be), 8'h01);
        chk("st_mem_we", 8'(write_enable), 8'd0);
        @(negedge CLK);
        bus.data_gnt     = 1'b0;
        bus.data_r_valid = 1'b1;
        #1 chk("st_wait_we", 8'(write_enable), 8'd0);
        chk("st_pc_we", 8'(pc_we), 8'd1);
        @(negedge CLK);
        bus.data_r_valid = 1'b0;
        #1 chk("st_done", 8'(busy), 8'd0);

        // Branch taken / not taken
        branch_taken = 1'b1;
        fetch(OP_BRANCH, 3'b000);
        chk("br_t_mode", 8'(MODE), 8'd1);
        chk("br_t_pc_we", 8'(pc_we), 8'd1);
        chk("br_t_we", 8'(write_enable), 8'd0);
        branch_taken = 1'b0;
        fetch(OP_BRANCH, 3'b001);
        chk("br_nt_mode", 8'(MODE), 8'd0);
        chk("br_nt_pc_we", 8'(pc_we), 8'd1);

        // JALR, LUI, AUIPC
        fetch(OP_JALR, 3'b000);
        chk("jalr_mode", 8'(MODE), 8'd2);
        chk("jalr_wb_sel", 8'(wb_sel), 8'd2);
        chk("jalr_we", 8'(write_enable), 8'd1);
        fetch(OP_LUI, 3'b000);
        chk("lui_mux2", 8'(ALUSrcMux2), 8'd1);
        chk("lui_aluop", 8'(ALUOp), 8'd2);
        fetch(OP_AUIPC, 3'b000);
        chk("auipc_mux1", 8'(ALUSrcMux1), 8'd1);
        chk("auipc_aluop", 8'(ALUOp), 8'd0);

        // STORE with 64-bit size on a 32-bit bus traps without data_req
        fetch(OP_STORE, 3'b011);
        @(negedge CLK);
        bus.data_gnt = 1'b1;
        #1 chk("st64_no_req", 8'(bus.data_req), 8'd0);
        @(negedge CLK);
        bus.data_gnt = 1'b0;
        #1 chk("st64_trap_ill", 8'(illegal_instr), 8'd1);
        chk("st64_trap_req", 8'(bus.data_req), 8'd0);
        chk("st64_trap_ireq", 8'(bus.instr_req), 8'd0);
        pulse_reset();

        // Illegal opcode: trap holds for 20 cycles despite stray grants
        fetch(7'b0000000, 3'b000);
        chk("ill_exec_flag", 8'(illegal_instr), 8'd1);
        chk("ill_exec_pc_we", 8'(pc_we), 8'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            bus.instr_gnt = 1'b1;
            bus.data_gnt  = 1'b1;
            #1 chk("ill_hold_flag", 8'(illegal_instr), 8'd1);
            chk("ill_hold_reqs", 8'({bus.instr_req, bus.data_req}), 8'd0);
        end
        @(negedge CLK);
        bus.instr_gnt = 1'b0;
        bus.data_gnt  = 1'b0;
        pulse_reset();

        // Withheld data_r_valid in MEM_WAIT
        fetch(OP_LOAD, 3'b010);
        @(negedge CLK);
        bus.data_gnt = 1'b1;
        #1 chk("to_req", 8'(bus.data_req), 8'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            bus.data_gnt = 1'b0;
            #1 chk("to_wait_berr", 8'(bus_error), 8'd0);
            chk("to_wait_busy", 8'(busy), 8'd1);
        end
`ifdef CTRL_TIMEOUT_EN
        @(negedge CLK);
        #1 chk("to_berr", 8'(bus_error), 8'd1);
        chk("to_trap_ill", 8'(illegal_instr), 8'd1);
        @(negedge CLK);
        #1 chk("to_berr_sticky", 8'(bus_error), 8'd1);
        pulse_reset();
        chk("to_berr_cleared", 8'(bus_error), 8'd0);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            #1 chk("nto_berr", 8'(bus_error), 8'd0);
            chk("nto_still_wait", 8'({busy, illegal_instr, write_enable}), 8'b100);
        end
        @(negedge CLK);
        bus.data_r_valid = 1'b1;
        #1 chk("nto_late_we", 8'(write_enable), 8'd1);
        chk("nto_late_pc_we", 8'(pc_we), 8'd1);
        @(negedge CLK);
        bus.data_r_valid = 1'b0;
        #1 chk("nto_done", 8'(busy), 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
- Multicycle control unit for the RV32I datapath; generalised successor to the two-state fetch controller.
- Sequences instruction fetch, execute, load/store and writeback over two req/gnt/r_valid memory ports (instruction and data).
- Covers LUI, AUIPC, OP-IMM, OP, LOAD, STORE, BRANCH, JAL and JALR.
- Drives PC mode, IR latch, register-file write, ALU source muxes, ALUOp and writeback select; traps on illegal opcodes.

Parameters:
- DATA_W, 32, data bus width (32 or 64); BE_W = DATA_W/8.
- TIMEOUT_CYCLES, 255, cycles allowed in a wait state before bus error (used only with CTRL_TIMEOUT_EN).

Ports:
- CLK  in  1  clock, rising edge.
- RES_N  in  1  asynchronous active-low reset.
- opcode  in  7  from IR.
- funct3  in  3  from IR.
- branch_taken  in  1  branch comparator result.
- instr_req  out  1  fetch request.
- instr_gnt  in  1  fetch grant.
- instr_r_valid  in  1  fetch data valid.
- ir_we  out  1  IR load enable.
- data_req  out  1  data request.
- data_gnt  in  1  data grant.
- data_r_valid  in  1  data response valid.
- data_we  out  1  1 = store.
- data_be  out  BE_W  byte enables, unshifted.
- MODE  out  2  PC source: 00 = +4, 01 = branch/JAL target, 10 = JALR target.
- pc_we  out  1  PC update enable.
- write_enable  out  1  register-file write.
- ALUSrcMux1  out  1  0 = Q0, 1 = PC.
- ALUSrcMux2  out  1  0 = Q1, 1 = immediate.
- ALUOp  out  2  00 = add, 01 = funct decode, 10 = pass B, 11 = idle.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- illegal_instr  out  1  trap flag.
- bus_error  out  1  timeout flag.
- busy  out  1  high in every state except FETCH.

Behaviour:
- Reset (RES_N low, asynchronous): state = FETCH. All outputs take their defaults: 0, except ALUOp = 11. Requests drop immediately, including when reset arrives mid-transaction.
- Outputs are combinational from state, opcode, funct3 and branch_taken. Unlisted outputs hold their defaults in every state.
- FETCH: instr_req = 1 until instr_gnt is sampled high, then -> FETCH_WAIT. instr_req stays asserted while gnt is low.
- FETCH_WAIT: instr_r_valid is sampled only in this state; r_valid in the gnt cycle is ignored. On r_valid: ir_we = 1, -> EXEC.
- EXEC, one cycle, decoded from opcode:
  - LUI: Mux2 = 1, ALUOp = 10, write_enable = 1.
  - AUIPC: Mux1 = 1, Mux2 = 1, ALUOp = 00, write_enable = 1.
  - OP-IMM: Mux2 = 1, ALUOp = 01, write_enable = 1.
  - OP: ALUOp = 01, write_enable = 1.
  - BRANCH: ALUOp = 01, MODE = branch_taken ? 01 : 00.
  - JAL: MODE = 01, wb_sel = 10, write_enable = 1.
  - JALR: MODE = 10, wb_sel = 10, write_enable = 1.
  - All of the above: pc_we = 1, -> FETCH.
  - LOAD/STORE: Mux2 = 1, ALUOp = 00 (address), -> MEM.
  - Any other opcode: illegal_instr = 1, -> TRAP.
- MEM:
  - Outputs: data_req = 1, Mux2 = 1, ALUOp = 00. data_we = 1 for STORE.
  - data_be from funct3: 000 -> 0x01, 001 -> 0x03, 010 -> 0x0F, 011 -> all ones (DATA_W = 64 only).
  - funct3 = 011 with DATA_W = 32, or any funct3 ≥ 100 on STORE -> TRAP without issuing data_req.
  - data_gnt high -> MEM_WAIT.
- MEM_WAIT: address path held (Mux2 = 1, ALUOp = 00). On data_r_valid:
  - LOAD: wb_sel = 01, write_enable = 1.
  - STORE: no register write.
  - Both: pc_we = 1, MODE = 00, -> FETCH.
- TRAP: illegal_instr held high, no requests. Only reset exits TRAP.
- Latency, zero-wait memory:
  - ALU/branch/jump instructions: 3 cycles (FETCH, FETCH_WAIT, EXEC).
  - Load/store: 5 cycles.
- Grant never early: gnt while the corresponding req is low is ignored.

Optional Feature:
- Macro: CTRL_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to FETCH_WAIT, MEM or MEM_WAIT and increments each cycle spent waiting there.
  - When the counter reaches TIMEOUT_CYCLES: bus_error = 1, -> TRAP, and bus_error stays high until reset.
  - FETCH is not timed.
- Undefined: no counter; waits are unbounded; bus_error tied to 0.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams.
  - state encoding: FETCH, FETCH_WAIT, EXEC, MEM, MEM_WAIT, TRAP.
  - ALUOp, MODE and wb_sel codes.
  - funct3 -> byte-enable constants.
- Sub-module ctrl_decode: purely combinational opcode -> control bundle (mux selects, ALUOp, wb_sel, class flags is_mem/is_store/is_branch/illegal). ctrl_mc instantiates it and gates its outputs by state.

Test Plan:
- Reset released, instr_gnt held low 3 cycles, then high; r_valid one cycle later with opcode 0110011 -> instr_req high 4 cycles; ir_we, then write_enable = 1, ALUOp = 01 and pc_we = 1 in EXEC; back in FETCH at cycle 7.
- LOAD (0000011, funct3 = 010), data_gnt delayed 2 cycles -> data_be = 0x0F, data_we = 0; on data_r_valid: wb_sel = 01, write_enable = 1, pc_we = 1.
- STORE funct3 = 000 -> data_we = 1, data_be = 0x01, write_enable never asserted; STORE funct3 = 011 with DATA_W = 32 -> TRAP, no data_req.
- BRANCH with branch_taken = 1 -> MODE = 01, pc_we = 1; with branch_taken = 0 -> MODE = 00. JALR -> MODE = 10, wb_sel = 10, write_enable = 1.
- Opcode 0000000 -> illegal_instr high from EXEC onward; no requests for 20 cycles; RES_N pulsed low -> FETCH, instr_req = 1 the first cycle after release.
- CTRL_TIMEOUT_EN, TIMEOUT_CYCLES = 4, data_r_valid withheld -> bus_error = 1 after 4 MEM_WAIT cycles, then TRAP; built without the macro, same stimulus waits indefinitely and bus_error stays 0.
